// File: rtl/e_mdu_ctrl.sv
// Execute-stage MDU controller: owns HI/LO and models fixed MULT/DIV latency via a busy window.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise DIV/DIVU behave as NONE.
module e_mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_rd
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("MUL_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("DIV_CYCLES must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] pend_hi_reg, pend_hi_next;
  logic [31:0] pend_lo_reg, pend_lo_next;

  // Full 64-bit products; operands are extended to 64 bits before multiplying.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

`ifdef MDU_DIV_EN
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  // Divide-by-zero and the single signed overflow case are pinned to fixed results.
  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (src_b == 32'd0) begin
      quot_s = 32'hFFFF_FFFF;
      rem_s  = src_a;
      quot_u = 32'hFFFF_FFFF;
      rem_u  = src_a;
    end else begin
      if (src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(src_a) / $signed(src_b);
        rem_s  = $signed(src_a) % $signed(src_b);
      end
      quot_u = src_a / src_b;
      rem_u  = src_a % src_b;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pend_hi_next = pend_hi_reg;
    pend_lo_next = pend_lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            OP_MULT: begin
              pend_hi_next = prod_s[63:32];
              pend_lo_next = prod_s[31:0];
              cnt_next     = MUL_LOAD;
              state_next   = BUSY;
            end
            OP_MULTU: begin
              pend_hi_next = prod_u[63:32];
              pend_lo_next = prod_u[31:0];
              cnt_next     = MUL_LOAD;
              state_next   = BUSY;
            end
`ifdef MDU_DIV_EN
            OP_DIV: begin
              pend_hi_next = rem_s;
              pend_lo_next = quot_s;
              cnt_next     = DIV_LOAD;
              state_next   = BUSY;
            end
            OP_DIVU: begin
              pend_hi_next = rem_u;
              pend_lo_next = quot_u;
              cnt_next     = DIV_LOAD;
              state_next   = BUSY;
            end
`endif
            OP_MTHI: hi_next = src_a;
            OP_MTLO: lo_next = src_a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Any start seen here is dropped; only the countdown advances.
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          hi_next    = pend_hi_reg;
          lo_next    = pend_lo_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pend_hi_reg <= pend_hi_next;
      pend_lo_reg <= pend_lo_next;
    end
  end

  assign busy   = (state_reg == BUSY);
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;

  always_comb begin
    mdu_rd = 32'd0;
    if (start && mdu_op == OP_MFHI) mdu_rd = hi_reg;
    else if (start && mdu_op == OP_MFLO) mdu_rd = lo_reg;
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed test-plan steps followed by random traffic
// checked against a cycle-level arithmetic reference model.
module tb_e_mdu_ctrl;

  localparam int MULC = 5;
  localparam int DIVC = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] mdu_rd;

  int tests = 0;
  int fails = 0;

  // Reference state: committed HI/LO, pending result and remaining busy cycles.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  always #5 clk = ~clk;

  e_mdu_ctrl #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .mdu_rd (mdu_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint x, y;
    longint unsigned ux, uy;
    if (sgn) begin
      ia = a; ib = b; x = ia; y = ib;
      return 64'(x * y);
    end
    ux = a; uy = b;
    return 64'(ux * uy);
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint x, y;
    longint unsigned ux, uy;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      ia = a; ib = b; x = ia; y = ib;
      return {32'(x % y), 32'(x / y)};
    end
    ux = a; uy = b;
    return {32'(ux % uy), 32'(ux / uy)};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(m_left > 0));
    check({tag, "_hi"}, hi_out, m_hi);
    check({tag, "_lo"}, lo_out, m_lo);
  endtask

  // One clock cycle: drive inputs, check the combinational read, advance model, check registers.
  task automatic cyc(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_rd;
    logic [63:0] r;
    start = s; mdu_op = op; src_a = a; src_b = b;
    #1;
    exp_rd = 32'd0;
    if (s && op == 4'd5) exp_rd = m_hi;
    if (s && op == 4'd6) exp_rd = m_lo;
    check("mdu_rd", mdu_rd, exp_rd);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s) begin
      case (op)
        4'd1, 4'd2: begin
          r = mul_ref(op == 4'd1, a, b);
          m_phi = r[63:32]; m_plo = r[31:0]; m_left = MULC;
        end
        4'd3, 4'd4: if (DIV_EN) begin
          r = div_ref(op == 4'd3, a, b);
          m_phi = r[63:32]; m_plo = r[31:0]; m_left = DIVC;
        end
        4'd7: m_hi = a;
        4'd8: m_lo = a;
        default: ;
      endcase
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_regs("cyc");
  endtask

  task automatic do_reset(input logic s, input logic [3:0] op);
    reset = 1'b1; start = s; mdu_op = op; src_a = $urandom; src_b = $urandom;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    check_regs("rst");
  endtask

  // Idles until busy drops; returns how many busy cycles were observed (capped at 20).
  task automatic drain(output int nb);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      nb++;
      cyc(1'b0, 4'd0, 32'd0, 32'd0);
    end
  endtask

  initial begin
    int nb;
    logic [31:0] old_lo;
    logic [3:0]  op;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 4'd0);
    repeat (3) cyc(1'b0, 4'd0, 32'd0, 32'd0);

    // Signed and unsigned multiply of -2 x 3.
    cyc(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    drain(nb);
    check("mult_busy_len", 32'(nb), 32'd5);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);
    cyc(1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3);
    drain(nb);
    check("multu_hi", hi_out, 32'd2);
    check("multu_lo", lo_out, 32'hFFFF_FFFA);

    // Divides; compiled-out divider must leave HI/LO untouched and never go busy.
    cyc(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    drain(nb);
    if (DIV_EN) begin
      check("div_busy_len", 32'(nb), 32'd10);
      check("div_lo", lo_out, 32'hFFFF_FFFD);
      check("div_hi", hi_out, 32'hFFFF_FFFF);
    end else begin
      check("nodiv_busy_len", 32'(nb), 32'd0);
      check("nodiv_lo", lo_out, 32'hFFFF_FFFA);
    end
    cyc(1'b1, 4'd4, 32'd7, 32'd0);
    drain(nb);
    if (DIV_EN) begin
      check("divu0_lo", lo_out, 32'hFFFF_FFFF);
      check("divu0_hi", hi_out, 32'd7);
    end
    cyc(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    drain(nb);
    if (DIV_EN) begin
      check("divovf_lo", lo_out, 32'h8000_0000);
      check("divovf_hi", hi_out, 32'd0);
    end

    // MTHI then MFHI.
    cyc(1'b1, 4'd7, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi_out, 32'h1234_5678);
    start = 1'b1; mdu_op = 4'd5; #1;
    check("mfhi_rd", mdu_rd, 32'h1234_5678);
    cyc(1'b1, 4'd5, 32'd0, 32'd0);

    // MTLO during an in-flight MULT is dropped; MFLO still reads old LO.
    old_lo = lo_out;
    cyc(1'b1, 4'd1, 32'd6, 32'd7);
    cyc(1'b1, 4'd8, 32'h5555_5555, 32'd0);
    start = 1'b1; mdu_op = 4'd6; #1;
    check("mflo_busy_rd", mdu_rd, old_lo);
    cyc(1'b1, 4'd6, 32'd0, 32'd0);
    drain(nb);
    check("mtlo_ignored_lo", lo_out, 32'd42);

    // Reset in the third busy cycle of a long op, then a clean MULT.
    cyc(1'b1, DIV_EN ? 4'd3 : 4'd1, 32'hFFFF_FFF9, 32'd2);
    cyc(1'b0, 4'd0, 32'd0, 32'd0);
    cyc(1'b0, 4'd0, 32'd0, 32'd0);
    do_reset(1'b0, 4'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    cyc(1'b1, 4'd1, 32'd4, 32'd5);
    drain(nb);
    check("post_rst_lo", lo_out, 32'd20);

    // Reset and start together: the op is dropped.
    do_reset(1'b1, 4'd7);
    cyc(1'b1, 4'd1, 32'd3, 32'd3);
    do_reset(1'b1, 4'd1);

    // Random traffic, including starts while busy and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      end else begin
        op = 4'($urandom_range(0, 15));
        cyc($urandom_range(0, 1) == 1, op, pick_operand(), pick_operand());
      end
    end
    drain(nb);
    check("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
